// File: rtl/udp_stream_pkg.sv
// udp_stream_pkg: shared state encoding and limits for the UDP streaming controller
package udp_stream_pkg;
  typedef enum logic [3:0] {
    IDLE, WAIT_DATA, ARP_REQ, ARP_WAIT, TX_REQ, WAIT_RAM_REQ, FILL, WAIT_END, GAP
  } state_t;
  localparam int ARP_MAX_RETRY = 8;
endpackage

// File: rtl/udp_fill_engine.sv
// udp_fill_engine: reads DATA_LEN FIFO bytes and writes them to the payload RAM one cycle later
module udp_fill_engine #(
  parameter int DATA_LEN = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] rdata,
  output logic       rd_en,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       done
);
  localparam int CW = $clog2(DATA_LEN + 1);
  logic [CW-1:0] cnt;
  assign rd_en   = run && cnt < CW'(DATA_LEN);
  assign wr_data = wr_en ? rdata : '0;
  assign done    = wr_en && cnt == CW'(DATA_LEN);
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt   <= '0;
      wr_en <= 1'b0;
    end else begin
      cnt   <= cnt + CW'(rd_en);
      wr_en <= rd_en;
    end
  end
endmodule

// File: rtl/udp_stream_ctrl.sv
// udp_stream_ctrl: packetises FIFO samples into fixed-length UDP packets with ARP resolve and IPG
module udp_stream_ctrl
  import udp_stream_pkg::*;
#(
  parameter int DATA_LEN       = 1024,
  parameter int CNT_W          = 12,
  parameter int ARP_RETRY_CYC  = 125000000,
  parameter int TX_TIMEOUT_CYC = 1000000,
  parameter int GAP_CYC        = 125
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [7:0]       sample_fifo_rdata,
  input  logic [CNT_W-1:0] sample_fifo_count,
  output logic             sample_fifo_rd_en,
  input  logic             mac_not_exist,
  output logic             arp_request_req,
  output logic             udp_tx_req,
  input  logic             udp_ram_data_req,
  output logic             ram_wr_en,
  output logic [7:0]       ram_wr_data,
  output logic [15:0]      udp_send_data_length,
  input  logic             mac_send_end,
  output logic             busy,
  output logic [31:0]      pkt_count,
  output logic             err_arp,
  output logic             err_tx_timeout
);
  state_t state, state_n;
  logic [31:0] timer;
  logic [3:0] retry;
  logic fill_done, enough, arp_tmo, tx_tmo, gap_done;
  assign enough   = 32'(sample_fifo_count) >= 32'(DATA_LEN);
  assign arp_tmo  = timer == 32'(ARP_RETRY_CYC - 1);
  assign tx_tmo   = timer == 32'(TX_TIMEOUT_CYC - 1);
  assign gap_done = timer == 32'(GAP_CYC - 1);
  assign udp_send_data_length = 16'(DATA_LEN);
  udp_fill_engine #(.DATA_LEN(DATA_LEN)) u_fill (
    .clk(clk), .rst(rst), .run(state == FILL), .rdata(sample_fifo_rdata),
    .rd_en(sample_fifo_rd_en), .wr_en(ram_wr_en), .wr_data(ram_wr_data), .done(fill_done)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         state_n = enable ? WAIT_DATA : IDLE;
      WAIT_DATA:    state_n = !enable ? IDLE : mac_not_exist ? ARP_REQ : enough ? TX_REQ : WAIT_DATA;
      ARP_REQ:      state_n = ARP_WAIT;
      ARP_WAIT:     state_n = !mac_not_exist ? WAIT_DATA : arp_tmo ? ARP_REQ : !enable ? IDLE : ARP_WAIT;
      TX_REQ:       state_n = WAIT_RAM_REQ;
      WAIT_RAM_REQ: state_n = udp_ram_data_req ? FILL : tx_tmo ? GAP : WAIT_RAM_REQ;
      FILL:         state_n = fill_done ? WAIT_END : FILL;
      WAIT_END:     state_n = (mac_send_end || tx_tmo) ? GAP : WAIT_END;
      GAP:          state_n = gap_done ? WAIT_DATA : GAP;
      default:      state_n = IDLE;
    endcase
  end
  always_comb begin
    arp_request_req = state == ARP_REQ;
    udp_tx_req      = state == TX_REQ;
    busy            = state != IDLE;
  end
  // retry counter saturates at the limit so retries can continue indefinitely
  always_ff @(posedge clk) begin
    if (rst) begin
      timer          <= '0;
      retry          <= '0;
      pkt_count      <= '0;
      err_arp        <= 1'b0;
      err_tx_timeout <= 1'b0;
    end else begin
      timer <= (state_n != state) ? '0 : timer + 32'(~&timer);
      if (state == ARP_REQ) retry <= retry + 4'(retry != 4'(ARP_MAX_RETRY));
      else if (state == ARP_WAIT && !mac_not_exist) retry <= '0;
      if (state == ARP_REQ && retry == 4'(ARP_MAX_RETRY - 1)) err_arp <= 1'b1;
      if (state == WAIT_END && mac_send_end) pkt_count <= pkt_count + 32'd1;
      if (tx_tmo && ((state == WAIT_RAM_REQ && !udp_ram_data_req) || (state == WAIT_END && !mac_send_end)))
        err_tx_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_udp_stream_ctrl.sv
// tb_udp_stream_ctrl: directed checks of ARP, packet fill, gap, timeout, enable drop and reset
module tb_udp_stream_ctrl;
  logic clk = 1'b0;
  logic rst, enable, mac_not_exist, udp_ram_data_req, mac_send_end;
  logic [7:0] sample_fifo_rdata = 8'h00;
  logic [11:0] sample_fifo_count;
  logic sample_fifo_rd_en, arp_request_req, udp_tx_req, ram_wr_en, busy, err_arp, err_tx_timeout;
  logic [7:0] ram_wr_data;
  logic [15:0] udp_send_data_length;
  logic [31:0] pkt_count;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, arp_cnt = 0, arp_prev = 0, arp_last = 0, tx_cnt = 0, wr_cnt = 0;
  int base, arp_base;
  logic [7:0] wr_buf [64];
  logic [7:0] fifo_ptr = 8'h00;

  udp_stream_ctrl #(.DATA_LEN(8), .CNT_W(12), .ARP_RETRY_CYC(100), .TX_TIMEOUT_CYC(50), .GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_fifo_rdata(sample_fifo_rdata),
    .sample_fifo_count(sample_fifo_count), .sample_fifo_rd_en(sample_fifo_rd_en),
    .mac_not_exist(mac_not_exist), .arp_request_req(arp_request_req), .udp_tx_req(udp_tx_req),
    .udp_ram_data_req(udp_ram_data_req), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
    .udp_send_data_length(udp_send_data_length), .mac_send_end(mac_send_end), .busy(busy),
    .pkt_count(pkt_count), .err_arp(err_arp), .err_tx_timeout(err_tx_timeout)
  );

  always #5 clk = ~clk;

  // FIFO model: byte value equals its position, data valid one cycle after rd_en
  always @(posedge clk) begin
    if (sample_fifo_rd_en) begin
      sample_fifo_rdata <= fifo_ptr;
      fifo_ptr <= fifo_ptr + 8'd1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (arp_request_req) begin
      arp_cnt++;
      arp_prev = arp_last;
      arp_last = cyc;
    end
    if (udp_tx_req) tx_cnt++;
    if (ram_wr_en) begin
      wr_buf[wr_cnt[5:0]] = ram_wr_data;
      wr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mac_not_exist = 1'b0; udp_ram_data_req = 1'b0;
    mac_send_end = 1'b0; sample_fifo_count = 12'd0;
    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_len", 32'(udp_send_data_length), 8);
    chk("rst_outs", {27'd0, arp_request_req, udp_tx_req, ram_wr_en, sample_fifo_rd_en, err_arp}, 0);
    chk("rst_err_to", 32'(err_tx_timeout), 0);
    // ARP resolve
    rst = 1'b0; enable = 1'b1; mac_not_exist = 1'b1;
    tick(30);
    chk("arp_one_req", arp_cnt, 1);
    mac_not_exist = 1'b0;
    tick(30);
    chk("arp_no_rereq", arp_cnt, 1);
    chk("no_tx_low_count", tx_cnt, 0);
    sample_fifo_count = 12'd16;
    tick(2);
    chk("tx_after_arp", tx_cnt, 1);
    // normal packet
    tick(2);
    udp_ram_data_req = 1'b1;
    tick(1);
    udp_ram_data_req = 1'b0;
    tick(10);
    chk("pkt_wr_cnt", wr_cnt, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("pkt_byte%0d", i), 32'(wr_buf[i]), 32'(i));
    chk("pkt_wait_end_busy", 32'(busy), 1);
    chk("pkt_before_end", pkt_count, 0);
    mac_send_end = 1'b1;
    tick(1);
    mac_send_end = 1'b0;
    chk("pkt_count1", pkt_count, 1);
    tick(4);
    chk("gap_no_tx", tx_cnt, 1);
    tick(1);
    chk("gap_next_tx", tx_cnt, 2);
    // timeout: ram request never arrives
    sample_fifo_count = 12'd0;
    base = wr_cnt;
    tick(50);
    chk("to_not_yet", 32'(err_tx_timeout), 0);
    tick(1);
    chk("to_set", 32'(err_tx_timeout), 1);
    chk("to_no_writes", wr_cnt - base, 0);
    tick(4);
    mac_send_end = 1'b1;
    tick(1);
    mac_send_end = 1'b0;
    chk("stray_end_ignored", pkt_count, 1);
    chk("to_wait_data_busy", 32'(busy), 1);
    // enable drop in FILL
    sample_fifo_count = 12'd16; udp_ram_data_req = 1'b1;
    tick(3);
    enable = 1'b0; udp_ram_data_req = 1'b0;
    base = wr_cnt;
    tick(9);
    chk("dis_wr_cnt", wr_cnt - base, 8);
    chk("dis_first", 32'(wr_buf[base]), 32'h08);
    chk("dis_last", 32'(wr_buf[base + 7]), 32'h0F);
    mac_send_end = 1'b1;
    tick(1);
    mac_send_end = 1'b0;
    tick(4);
    chk("dis_wait_data", 32'(busy), 1);
    tick(1);
    chk("dis_idle", 32'(busy), 0);
    chk("dis_pkt", pkt_count, 2);
    // ARP failure
    enable = 1'b1; mac_not_exist = 1'b1; sample_fifo_count = 12'd0;
    arp_base = arp_cnt;
    tick(709);
    chk("arpf_8_req", arp_cnt - arp_base, 8);
    chk("arpf_period", arp_last - arp_prev, 101);
    chk("arpf_not_yet", 32'(err_arp), 0);
    tick(1);
    chk("arpf_err", 32'(err_arp), 1);
    chk("to_sticky", 32'(err_tx_timeout), 1);
    // reset mid-FILL
    mac_not_exist = 1'b0; sample_fifo_count = 12'd16; udp_ram_data_req = 1'b1;
    tick(7);
    chk("mid_fill_wr", 32'(ram_wr_en), 1);
    rst = 1'b1; enable = 1'b0; udp_ram_data_req = 1'b0;
    tick(1);
    chk("rstf_rd", 32'(sample_fifo_rd_en), 0);
    chk("rstf_wr", 32'(ram_wr_en), 0);
    chk("rstf_pkt", pkt_count, 0);
    chk("rstf_busy", 32'(busy), 0);
    chk("rstf_errs", {30'd0, err_arp, err_tx_timeout}, 0);
    rst = 1'b0;
    base = wr_cnt;
    tick(5);
    chk("rstf_no_wr", wr_cnt - base, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
